bpm_link_merge_arbiter: RTL
===========================

// Module: bpm_link_merge_arbiter
// PURPOSE
//  Merges the CCW and CW BPM link record streams (112-bit strobed records, no backpressure)
//  into one AXI-stream-style output for the forwarding state machine.
//  Per-input FIFO buffering, round-robin arbitration, per-session flush on auroraFAstrobe
//  and overflow reporting. Sits between the two per-link readers and the merged-record
//  consumer; runs entirely in the Aurora user clock domain.
// PARAMETERS
//  DATA_WIDTH  112  record width {header[15:0], X[31:0], Y[31:0], S[31:0]}
//  FIFO_DEPTH  16   entries per input FIFO; power of 2, >= 2
//  PTR_WIDTH   $clog2(FIFO_DEPTH)  derived; occupancy width is PTR_WIDTH+1
// PORTS
//  auroraUserClk     in   1           sole clock
//  auroraUserResetN  in   1           synchronous reset, active low
//  auroraFAstrobe    in   1           start of transfer session; flushes block
//  ccwValid          in   1           CCW record strobe (one record per cycle)
//  ccwData           in   DATA_WIDTH  CCW record
//  cwValid           in   1           CW record strobe
//  cwData            in   DATA_WIDTH  CW record
//  mergedTDATA       out  DATA_WIDTH  granted record
//  mergedTVALID      out  1           mergedTDATA valid
//  mergedTREADY      in   1           consumer accepts when TVALID&TREADY
//  mergedTSOURCE     out  1           0=CCW, 1=CW origin of mergedTDATA
//  ccwOverflow       out  1           previous session dropped >=1 CCW record
//  cwOverflow        out  1           previous session dropped >=1 CW record
// BEHAVIOUR
//  - Reset (auroraUserResetN=0 at edge): FIFOs empty; mergedTVALID=0, mergedTDATA=0,
//    mergedTSOURCE=0, overflow outputs/sticky flags=0, lastGrant=CW (CCW wins first tie).
//  - FIFO write: xValid writes at edge if occupancy<FIFO_DEPTH, or if that FIFO is popped
//    in the same cycle (occupancy unchanged). Otherwise record dropped, sticky drop flag set.
//  - Output register: single stage. Loadable when mergedTVALID=0 or TVALID&TREADY.
//    While TVALID=1 and TREADY=0, TDATA/TSOURCE hold stable.
//  - Arbitration (when loadable): both FIFOs non-empty -> grant input != lastGrant;
//    one non-empty -> grant it; none -> TVALID<=0. Grant pops that FIFO head into output
//    register, sets TVALID=1, TSOURCE, lastGrant. Non-empty = occupancy before this edge.
//  - Latency: record strobed into empty FIFO at edge k appears with TVALID=1 after
//    edge k+1. Sustained throughput 1 record/cycle with TREADY held high.
//  - Ordering: records from one input emerge in arrival order; inputs alternate under load.
//  - auroraFAstrobe (priority over all but reset): at edge, copy sticky drop flags to
//    ccwOverflow/cwOverflow, clear sticky flags, empty both FIFOs, TVALID<=0,
//    lastGrant<=CW. Records strobed in the strobe cycle are discarded, not counted as drops.
//    Overflow outputs hold until the next strobe or reset.
//  - Pointers wrap modulo FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH.
// CONFIGURATION
//  MERGE_HIGHWATER_EN defined: adds outputs ccwHighWater, cwHighWater [PTR_WIDTH:0] =
//    peak FIFO occupancy during previous session, latched at auroraFAstrobe; running peak
//    cleared to 0 at strobe/reset; peak includes the entry written that cycle.
//  Not defined: ports absent, no peak-tracking logic.
// TESTING
//  1 Reset, single CCW strobe (data A) with TREADY=1 -> TVALID at +2 cycles, TDATA=A, TSOURCE=0, one beat.
//  2 Both inputs strobe every cycle x4 (C0..C3, W0..W3), TREADY=1 -> output C0,W0,C1,W1,...,W3 contiguous.
//  3 TREADY=0, 20 CCW strobes -> 16 buffered + 1 in output reg; strobe FA -> ccwOverflow=1, TVALID=0.
//  4 TREADY toggled 1/0 during stream -> TDATA stable while stalled, no loss or duplication vs. model.
//  5 FA strobe coincident with ccwValid and a pending TVALID -> record dropped, TVALID=0, overflow flags=0.
//  6 MERGE_HIGHWATER_EN, 5 CW records with TREADY=0 then FA -> cwHighWater=4 (1 in output reg), ccwHighWater=0.

Source files
------------

// File: rtl/bpm_link_merge_arbiter.sv
// Merges CCW/CW BPM link records into one stream with round-robin arbitration.
// Optional MERGE_HIGHWATER_EN adds per-session peak FIFO occupancy outputs.
module bpm_link_merge_fifo #(
  parameter int DW = 112,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [PW:0]   count
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;

  always_ff @(posedge clk) begin
    if (!rstN || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= din;
  end

  assign head = mem[rdPtr];
endmodule

module bpm_link_merge_arbiter #(
  parameter int DATA_WIDTH = 112,
  parameter int FIFO_DEPTH = 16,
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  auroraUserClk,
  input  logic                  auroraUserResetN,
  input  logic                  auroraFAstrobe,
  input  logic                  ccwValid,
  input  logic [DATA_WIDTH-1:0] ccwData,
  input  logic                  cwValid,
  input  logic [DATA_WIDTH-1:0] cwData,
  output logic [DATA_WIDTH-1:0] mergedTDATA,
  output logic                  mergedTVALID,
  input  logic                  mergedTREADY,
  output logic                  mergedTSOURCE,
  output logic                  ccwOverflow,
  output logic                  cwOverflow
`ifdef MERGE_HIGHWATER_EN
  ,
  output logic [PTR_WIDTH:0]    ccwHighWater,
  output logic [PTR_WIDTH:0]    cwHighWater
`endif
);
  localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] ccwHead;
  logic [DATA_WIDTH-1:0] cwHead;
  logic [PTR_WIDTH:0]    ccwCnt;
  logic [PTR_WIDTH:0]    cwCnt;
  logic ccwPush, cwPush, ccwPop, cwPop;
  logic ccwDrop, cwDrop, loadable;
  logic lastGrant;
  logic ccwSticky, cwSticky;

  always_comb begin
    loadable = !mergedTVALID || mergedTREADY;
    ccwPop = 1'b0;
    cwPop = 1'b0;
    // lastGrant=1 means CW went last, so CCW wins a tie
    if (loadable) begin
      if (ccwCnt != '0 && cwCnt != '0) begin
        ccwPop = lastGrant;
        cwPop = !lastGrant;
      end else if (ccwCnt != '0) begin
        ccwPop = 1'b1;
      end else if (cwCnt != '0) begin
        cwPop = 1'b1;
      end
    end
    ccwPush = ccwValid && !auroraFAstrobe && (ccwCnt != FULL || ccwPop);
    cwPush = cwValid && !auroraFAstrobe && (cwCnt != FULL || cwPop);
    ccwDrop = ccwValid && !auroraFAstrobe && !ccwPush;
    cwDrop = cwValid && !auroraFAstrobe && !cwPush;
  end

  bpm_link_merge_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) uCcwFifo (
    .clk(auroraUserClk), .rstN(auroraUserResetN), .flush(auroraFAstrobe),
    .push(ccwPush), .pop(ccwPop), .din(ccwData), .head(ccwHead), .count(ccwCnt)
  );

  bpm_link_merge_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) uCwFifo (
    .clk(auroraUserClk), .rstN(auroraUserResetN), .flush(auroraFAstrobe),
    .push(cwPush), .pop(cwPop), .din(cwData), .head(cwHead), .count(cwCnt)
  );

  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN) begin
      mergedTVALID <= 1'b0;
      mergedTDATA <= '0;
      mergedTSOURCE <= 1'b0;
      lastGrant <= 1'b1;
      ccwSticky <= 1'b0;
      cwSticky <= 1'b0;
      ccwOverflow <= 1'b0;
      cwOverflow <= 1'b0;
    end else if (auroraFAstrobe) begin
      mergedTVALID <= 1'b0;
      lastGrant <= 1'b1;
      ccwOverflow <= ccwSticky;
      cwOverflow <= cwSticky;
      ccwSticky <= 1'b0;
      cwSticky <= 1'b0;
    end else begin
      if (ccwDrop) ccwSticky <= 1'b1;
      if (cwDrop) cwSticky <= 1'b1;
      if (loadable) begin
        mergedTVALID <= ccwPop || cwPop;
        if (ccwPop) begin
          mergedTDATA <= ccwHead;
          mergedTSOURCE <= 1'b0;
          lastGrant <= 1'b0;
        end else if (cwPop) begin
          mergedTDATA <= cwHead;
          mergedTSOURCE <= 1'b1;
          lastGrant <= 1'b1;
        end
      end
    end
  end

`ifdef MERGE_HIGHWATER_EN
  logic [PTR_WIDTH:0] ccwPeak, cwPeak, ccwNext, cwNext;

  always_comb begin
    ccwNext = ccwCnt + (PTR_WIDTH+1)'(ccwPush) - (PTR_WIDTH+1)'(ccwPop);
    cwNext = cwCnt + (PTR_WIDTH+1)'(cwPush) - (PTR_WIDTH+1)'(cwPop);
  end

  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN) begin
      ccwPeak <= '0;
      cwPeak <= '0;
      ccwHighWater <= '0;
      cwHighWater <= '0;
    end else if (auroraFAstrobe) begin
      ccwHighWater <= ccwPeak;
      cwHighWater <= cwPeak;
      ccwPeak <= '0;
      cwPeak <= '0;
    end else begin
      if (ccwNext > ccwPeak) ccwPeak <= ccwNext;
      if (cwNext > cwPeak) cwPeak <= cwNext;
    end
  end
`endif
endmodule
